phase_scheduler: RTL

Timing and table scheduler for the intersection light controller. It receives the current phase's duration in seconds and counts it down on a 1 s tick derived from the 10 kHz `clk`. When the phase expires it issues a one-cycle `advance` pulse that steps the light-sequencing FSM. At each cycle boundary it selects the timing table (A/B/C/D) from debounced vehicle sensors and latched pedestrian requests.

---
 rtl/phase_scheduler.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/phase_scheduler.sv
// Phase timer and timing-table scheduler for the intersection light controller.
// Counts each phase down on a 1 s tick and picks the timing table at every cycle boundary.
module phase_scheduler #(
  parameter int CLK_HZ        = 10000,
  parameter int SENSOR_FILTER = 16,
  parameter int MIN_SECONDS   = 1
) (
  input  logic       clk,
  input  logic       reset_general,
  input  logic       enable_general,
  input  logic       SNN,
  input  logic       SNS,
  input  logic       STH,
  input  logic       PNN,
  input  logic       PNS,
  input  logic       PTH,
  input  logic [7:0] phase_duration,
  input  logic       phase_last,
  output logic       advance,
  output logic       cycle_start,
  output logic [1:0] tabla,
  output logic [7:0] seconds_left,
  output logic [2:0] ped_pending
);

  localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int FW = $clog2(SENSOR_FILTER + 1);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_HZ - 1);
  localparam logic [FW-1:0] FILT_MAX  = FW'(SENSOR_FILTER - 1);
  localparam logic [7:0]    MIN_SEC   = 8'(MIN_SECONDS);

  typedef enum logic [1:0] {IDLE, LOAD, COUNT, ADVANCE} state_t;

  state_t        state_reg;
  logic [5:0]    raw_in;
  logic [5:0]    sync1_reg;
  logic [5:0]    sync2_reg;
  logic [2:0]    sensor_sync;
  logic [2:0]    ped_set;
  logic [2:0]    sensor_filt;
  logic [PW-1:0] presc_reg;
  logic          sec_tick;
  logic [1:0]    tabla_next;
  logic [7:0]    load_value;

  // Bit order {PTH,PNS,PNN,STH,SNS,SNN}: sensors in [2:0], buttons in [5:3]
  assign raw_in = {PTH, PNS, PNN, STH, SNS, SNN};

  always_ff @(posedge clk or negedge reset_general) begin
    if (!reset_general) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= raw_in;
      sync2_reg <= sync1_reg;
    end
  end

  assign sensor_sync = sync2_reg[2:0];
  assign ped_set     = sync2_reg[5:3];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_filter
      logic [FW-1:0] cnt_reg;
      logic          filt_reg;

      // Any cycle agreeing with the filtered value restarts the stability count
      always_ff @(posedge clk or negedge reset_general) begin
        if (!reset_general) begin
          cnt_reg  <= '0;
          filt_reg <= 1'b0;
        end else if (sensor_sync[gi] == filt_reg) begin
          cnt_reg <= '0;
        end else if (cnt_reg == FILT_MAX) begin
          filt_reg <= sensor_sync[gi];
          cnt_reg  <= '0;
        end else begin
          cnt_reg <= cnt_reg + FW'(1);
        end
      end

      assign sensor_filt[gi] = filt_reg;
    end
  endgenerate

  assign sec_tick    = (state_reg == COUNT) && (presc_reg == PRESC_MAX);
  assign load_value  = (phase_duration == 8'd0) ? MIN_SEC : phase_duration;
  assign cycle_start = advance & phase_last;

  // sensor_filt = {STH,SNS,SNN}; pending pedestrians force table A
  always_comb begin
    tabla_next = 2'b00;
    if (ped_pending == 3'b000) begin
      case (sensor_filt)
        3'b100:  tabla_next = 2'b01;
        3'b001:  tabla_next = 2'b10;
        3'b010:  tabla_next = 2'b11;
        default: tabla_next = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_general) begin
    if (!reset_general) begin
      state_reg    <= IDLE;
      advance      <= 1'b0;
      tabla        <= 2'b00;
      seconds_left <= 8'd0;
      presc_reg    <= '0;
      ped_pending  <= 3'b000;
    end else begin
      ped_pending <= ped_pending | ped_set;
      if (!enable_general) begin
        state_reg <= IDLE;
        advance   <= 1'b0;
        presc_reg <= '0;
      end else begin
        case (state_reg)
          IDLE: state_reg <= LOAD;
          LOAD: begin
            seconds_left <= load_value;
            presc_reg    <= '0;
            state_reg    <= COUNT;
          end
          COUNT: begin
            if (sec_tick) begin
              presc_reg <= '0;
              if (seconds_left != 8'd0) seconds_left <= seconds_left - 8'd1;
              if (seconds_left <= 8'd1) begin
                state_reg <= ADVANCE;
                advance   <= 1'b1;
              end
            end else begin
              presc_reg <= presc_reg + PW'(1);
            end
          end
          ADVANCE: begin
            advance   <= 1'b0;
            state_reg <= LOAD;
            // A request landing on the clearing edge survives into the next cycle
            if (phase_last) begin
              tabla       <= tabla_next;
              ped_pending <= ped_set;
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
